// File: rtl/spi_regctrl.sv
// SPI register controller: replays a programmable init table after reset, then
// serves gain writes and generic register access from the command slave bus.
module spi_regctrl #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NCS        = 1,
  parameter int unsigned SCLK_HALF  = 1,
  parameter int unsigned GAP        = 2,
  parameter int unsigned INIT_DEPTH = 20,
  parameter logic [INIT_DEPTH*(1+DATA_W)-1:0] INIT_TABLE = '0,
  parameter logic [7:0] CHIP_ID = 8'h06
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              spi_sclk,
  output logic              spi_sdio,
  input  logic              spi_sdo,
  output logic [NCS-1:0]    spi_sen_n,
  input  logic [5:0]        cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_rqst,
  output logic              cmd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_done,
  output logic              busy
);
  localparam int unsigned FRAME_W = 3 + ADDR_W + DATA_W;
  localparam int unsigned ENT_W   = 1 + DATA_W;
  localparam int unsigned PTR_W   = $clog2(INIT_DEPTH + 1);
  localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);
  localparam logic [15:0] GAP_LAST  = 16'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [7:0]  BIT_LAST  = 8'(FRAME_W - 1);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(INIT_DEPTH);
  localparam logic [2:0]  NCS_L = 3'(NCS);

  typedef enum logic [2:0] {INIT_SCAN, INIT_SEND, IDLE, SHIFT, GAP_WAIT} state_t;
  state_t state;

  logic [FRAME_W-1:0] tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic [15:0]        cnt;
  logic [7:0]         bit_cnt;
  logic [PTR_W-1:0]   ptr;
  logic               is_read;
  logic [3:0]         tx_gain;
  logic [6:0]         rx_gain;
  logic [ENT_W-1:0]   entry;
  logic [5:0]         rx_code;
  logic               cmd_frame;
  logic [FRAME_W-1:0] cmd_word;
  logic [NCS-1:0]     cmd_sel;
  logic               unused_bits;

  assign unused_bits = ^{cmd_data, tx_sh[FRAME_W-1]};

  function automatic logic [FRAME_W-1:0] make_frame(input logic rw,
                                                    input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] d);
    return {rw, 2'b00, a, d};
  endfunction

  always_comb begin
    entry = '0;
    if (ptr < PTR_END) entry = INIT_TABLE[32'(ptr) * ENT_W +: ENT_W];
  end

  always_comb begin
    if (cmd_data[6])      rx_code = cmd_data[5:0];
    else if (cmd_data[5]) rx_code = ~cmd_data[5:0];
    else                  rx_code = {1'b1, cmd_data[4:0]};
  end

  // cmd_frame is low for ack-only commands (unchanged gain, foreign ID, bad cs)
  always_comb begin
    cmd_frame = 1'b0;
    cmd_word  = '0;
    cmd_sel   = NCS'(1);
    case (cmd_addr)
      6'h09: begin
        cmd_frame = cmd_data[31:28] != tx_gain;
        cmd_word  = make_frame(1'b0, ADDR_W'(5'h0a), DATA_W'({4'b0100, cmd_data[31:28]}));
      end
      6'h0a: begin
        cmd_frame = cmd_data[6:0] != rx_gain;
        cmd_word  = make_frame(1'b0, ADDR_W'(5'h09), DATA_W'({2'b01, rx_code}));
      end
      6'h3b: begin
        cmd_frame = (cmd_data[31:24] == CHIP_ID) && ({1'b0, cmd_data[22:21]} < NCS_L);
        cmd_word  = make_frame(cmd_data[23], ADDR_W'(cmd_data[20:16]), cmd_data[DATA_W-1:0]);
        cmd_sel   = NCS'(1) << cmd_data[22:21];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT_SCAN;
      spi_sen_n <= '1;
      spi_sclk  <= 1'b0;
      spi_sdio  <= 1'b0;
      cmd_ack   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      tx_gain   <= 4'h0;
      rx_gain   <= 7'h40;
      ptr       <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cnt       <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
    end else begin
      cmd_ack  <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b1;
      case (state)
        INIT_SCAN: begin
          if (ptr == PTR_END) begin
            init_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (entry[ENT_W-1]) begin
            tx_sh     <= make_frame(1'b0, ADDR_W'(ptr), entry[DATA_W-1:0]);
            spi_sdio  <= 1'b0;
            spi_sen_n <= '0;
            is_read   <= 1'b0;
            cnt       <= '0;
            bit_cnt   <= '0;
            state     <= INIT_SEND;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        IDLE: begin
          busy <= 1'b0;
          if (cmd_rqst && !cmd_ack && init_done) begin
            cmd_ack <= 1'b1;
            if (cmd_addr == 6'h09) tx_gain <= cmd_data[31:28];
            if (cmd_addr == 6'h0a) rx_gain <= cmd_data[6:0];
            if (cmd_frame) begin
              tx_sh     <= cmd_word;
              spi_sdio  <= cmd_word[FRAME_W-1];
              spi_sen_n <= ~cmd_sel;
              is_read   <= cmd_word[FRAME_W-1];
              cnt       <= '0;
              bit_cnt   <= '0;
              busy      <= 1'b1;
              state     <= SHIFT;
            end
          end
        end
        INIT_SEND, SHIFT: begin
          if (cnt != HALF_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              rx_sh    <= {rx_sh[DATA_W-2:0], spi_sdo};
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                spi_sen_n <= '1;
                spi_sdio  <= 1'b0;
                if (is_read) begin
                  rd_data  <= rx_sh;
                  rd_valid <= 1'b1;
                end
                if (state == INIT_SEND) ptr <= ptr + 1'b1;
                state <= GAP_WAIT;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                tx_sh    <= tx_sh << 1;
                spi_sdio <= tx_sh[FRAME_W-2];
              end
            end
          end
        end
        GAP_WAIT: begin
          if (cnt != GAP_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (init_done) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= INIT_SCAN;
            end
          end
        end
        default: state <= INIT_SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_regctrl.sv
// Directed bench for spi_regctrl: init replay, gain and generic commands,
// readback, mid-frame reset, and a wide slow-clock instance.
module tb_spi_regctrl;
  localparam logic [179:0] TABLE1 = (180'(9'h136) << 36) | (180'(9'h121) << 63);
  localparam logic [67:0]  TABLE2 = 68'(17'h1BEEF) << 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sclk1, sdio1, sdo1;
  logic [1:0]  sen1;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_rqst, cmd_ack1, rd_valid1, init_done1, busy1;
  logic [7:0]  rd_data1;
  logic        sclk2, sdio2, cmd_ack2, rd_valid2, init_done2, busy2;
  logic [0:0]  sen2;
  logic [15:0] rd_data2;

  spi_regctrl #(.NCS(2), .INIT_TABLE(TABLE1)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(sclk1), .spi_sdio(sdio1), .spi_sdo(sdo1),
    .spi_sen_n(sen1), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rqst(cmd_rqst),
    .cmd_ack(cmd_ack1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .init_done(init_done1), .busy(busy1));

  spi_regctrl #(.ADDR_W(6), .DATA_W(16), .SCLK_HALF(3), .INIT_DEPTH(4), .INIT_TABLE(TABLE2)) dut2 (
    .clk(clk), .rst_n(rst_n), .spi_sclk(sclk2), .spi_sdio(sdio2), .spi_sdo(1'b0),
    .spi_sen_n(sen2), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rqst(1'b0),
    .cmd_ack(cmd_ack2), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .init_done(init_done2), .busy(busy2));

  int unsigned checks = 0, errors = 0;
  int unsigned nfr1 = 0, len1 = 0, bits1 = 0, hi1 = 0, min_gap1 = 1000;
  int unsigned acks = 0, early_acks = 0, rvs = 0;
  logic [31:0] fr1 = '0;
  logic        psclk1 = 1'b0;
  logic [31:0] frames [0:31];
  int unsigned lens [0:31];
  logic [1:0]  cs_hist [0:31];
  logic [1:0]  cs_cur = 2'b11;
  logic [15:0] resp = 16'h00C3;

  int unsigned nfr2 = 0, len2 = 0, bits2 = 0, lastlen2 = 0, lastbits2 = 0;
  logic [31:0] fr2 = '0, lastfr2 = '0;
  logic        psclk2 = 1'b0;

  logic [1:0]  sen_at_ack;
  logic        done_at_ack;
  int unsigned nfr_at_ack;

  // Frame monitor and readback responder for the two-chip-select instance
  always @(negedge clk) begin
    if (cmd_ack1) begin
      acks++;
      if (!init_done1) early_acks++;
    end
    if (rd_valid1) rvs++;
    if (sen1 != 2'b11) begin
      if (len1 == 0) begin
        if (nfr1 > 0 && hi1 < min_gap1) min_gap1 = hi1;
        cs_cur = sen1;
      end
      len1++;
      if (sclk1 && !psclk1) begin
        fr1 = {fr1[30:0], sdio1};
        bits1++;
      end
      if (!sclk1) sdo1 = (bits1 < 16) ? resp[4'(15 - bits1)] : 1'b0;
    end else begin
      if (len1 != 0) begin
        if (nfr1 < 32) begin
          frames[nfr1]  = fr1;
          lens[nfr1]    = len1;
          cs_hist[nfr1] = cs_cur;
        end
        nfr1++;
        len1  = 0;
        bits1 = 0;
        fr1   = '0;
        hi1   = 0;
      end
      hi1++;
    end
    psclk1 = sclk1;
  end

  always @(negedge clk) begin
    if (!sen2[0]) begin
      len2++;
      if (sclk2 && !psclk2) begin
        fr2 = {fr2[30:0], sdio2};
        bits2++;
      end
    end else if (len2 != 0) begin
      nfr2++;
      lastfr2   = fr2;
      lastlen2  = len2;
      lastbits2 = bits2;
      len2  = 0;
      bits2 = 0;
      fr2   = '0;
    end
    psclk2 = sclk2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [5:0] a, input logic [31:0] d, input string tag);
    int unsigned n;
    int unsigned a0;
    a0 = acks;
    cmd_addr = a;
    cmd_data = d;
    cmd_rqst = 1'b1;
    n = 0;
    while (!cmd_ack1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack"}, 32'(cmd_ack1), 32'd1);
    sen_at_ack  = sen1;
    done_at_ack = init_done1;
    nfr_at_ack  = nfr1;
    cmd_rqst = 1'b0;
    n = 0;
    while (busy1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_one_ack"}, acks - a0, 32'd1);
  endtask

  initial begin
    int unsigned n0;
    rst_n = 1'b0;
    cmd_rqst = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    sdo1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sen", 32'(sen1), 32'h3);
    chk("reset_outs", 32'({sclk1, sdio1, cmd_ack1, rd_valid1, init_done1, busy1}), 32'h0);
    chk("reset_rd_data", 32'(rd_data1), 32'h0);

    // tx gain request raised during init: must stall until init completes
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_busy", 32'(busy1), 32'd1);
    send_cmd(6'h09, 32'h5000_0000, "tx_gain");
    chk("early_acks", early_acks, 32'd0);
    chk("ack_after_init", 32'(done_at_ack), 32'd1);
    chk("init_frame_cnt", nfr_at_ack, 32'd2);
    chk("sen_low_at_ack", 32'(sen_at_ack), 32'h2);
    chk("init_f0", frames[0], 32'h0436);
    chk("init_f1", frames[1], 32'h0721);
    chk("init_len0", lens[0], 32'd32);
    chk("init_len1", lens[1], 32'd32);
    chk("init_cs0", 32'(cs_hist[0]), 32'h0);
    chk("init_cs1", 32'(cs_hist[1]), 32'h0);
    chk("tx_frame", frames[2], 32'h0A45);
    chk("tx_cs", 32'(cs_hist[2]), 32'h2);

    send_cmd(6'h0a, 32'h0000_0020, "rx_gain");
    chk("rx_frame", frames[3], 32'h095F);
    chk("rx_cnt", nfr1, 32'd4);
    send_cmd(6'h0a, 32'h0000_0020, "rx_same");
    send_cmd(6'h09, 32'h5000_0000, "tx_same");
    send_cmd(6'h11, 32'hFFFF_FFFF, "bad_addr");
    send_cmd(6'h3b, 32'h07A3_0000, "bad_id");
    send_cmd(6'h3b, 32'h06C3_0000, "bad_cs");
    chk("ack_only_no_frames", nfr1, 32'd4);
    chk("writes_no_rd_valid", rvs, 32'd0);
    chk("min_gap", 32'(min_gap1 >= 2), 32'd1);

    send_cmd(6'h3b, 32'h06A3_0000, "gen_read");
    chk("read_frame", frames[4], 32'h8300);
    chk("read_cs", 32'(cs_hist[4]), 32'h1);
    chk("read_len", lens[4], 32'd32);
    chk("rd_data", 32'(rd_data1), 32'hC3);
    chk("rd_valid_once", rvs, 32'd1);

    chk("wide_done", 32'(init_done2), 32'd1);
    chk("wide_cnt", nfr2, 32'd1);
    chk("wide_frame", lastfr2, 32'h002BEEF);
    chk("wide_len", lastlen2, 32'd150);
    chk("wide_bits", lastbits2, 32'd25);

    // reset while a write frame is shifting
    n0 = nfr1;
    cmd_addr = 6'h3b;
    cmd_data = 32'h0601_0055;
    cmd_rqst = 1'b1;
    for (int i = 0; i < 20 && !cmd_ack1; i++) @(negedge clk);
    chk("abort_ack", 32'(cmd_ack1), 32'd1);
    cmd_rqst = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_sen", 32'(sen1), 32'h3);
    chk("abort_sclk", 32'(sclk1), 32'd0);
    chk("abort_done", 32'(init_done1), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_cmd(6'h09, 32'h0000_0000, "tx_reset_val");
    send_cmd(6'h0a, 32'h0000_0040, "rx_reset_val");
    chk("abort_frames", nfr1, n0 + 3);
    chk("abort_partial", 32'(lens[n0] < 32), 32'd1);
    chk("reinit_f0", frames[n0 + 1], 32'h0436);
    chk("reinit_f1", frames[n0 + 2], 32'h0721);
    chk("abort_no_rd_valid", rvs, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_regctrl.md
Name: spi_regctrl

Overview:
Parametrised SPI register controller for the AD9866 and similar codec/RFFE parts. It replays a programmable init table after reset. It then serves host command-slave writes: generic register writes, TX/RX gain writes, and register readback. Frame width, divider, init depth and chip-select count are configurable. It sits between the command bus decoder and the RFFE SPI pins.

Parameters:
ADDR_W, 5, register address bits in frame
DATA_W, 8, register data bits in frame; FRAME_W = 3+ADDR_W+DATA_W
NCS, 1, number of chip selects (1..4)
SCLK_HALF, 1, clk cycles per sclk half-period (>=1)
GAP, 2, minimum clk cycles sen_n high between frames
INIT_DEPTH, 20, init table entries; entry i targets address i
INIT_TABLE, 20*(1+DATA_W)'h0, flat table; entry i = bits [(i+1)*(1+DATA_W)-1 : i*(1+DATA_W)], MSB = send-enable
CHIP_ID, 8'h06, cmd_data[31:24] value selecting generic access

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
spi_sclk  out  1  SPI clock, idle low
spi_sdio  out  1  SPI serial data out, MSB first
spi_sdo  in  1  SPI serial data in (readback)
spi_sen_n  out  NCS  active-low chip enables
cmd_addr  in  6  command slave address
cmd_data  in  32  command slave data
cmd_rqst  in  1  request; held until cmd_ack
cmd_ack  out  1  one-cycle acknowledge
rd_data  out  DATA_W  last readback value
rd_valid  out  1  one-cycle pulse, rd_data updated
init_done  out  1  init table fully processed
busy  out  1  frame in progress or gap not elapsed

Behaviour:
- Reset (rst_n=0 at clk edge): spi_sen_n all 1, spi_sclk 0, spi_sdio 0, cmd_ack 0, rd_valid 0, rd_data 0, init_done 0, busy 0. Gains reset to tx=4'h0, rx=7'h40. Init pointer reset to 0. A frame in flight is aborted: sen_n goes high at that edge and no partial completion is reported.
- Frame format: {rw, 2'b00, addr[ADDR_W-1:0], data[DATA_W-1:0]}, where rw=1 means read. sdio is updated while sclk is low. The device samples on sclk rising. spi_sdo is captured at the clk edge that raises sclk. Each bit takes 2*SCLK_HALF clks; a frame takes FRAME_W*2*SCLK_HALF clks. After a frame, sen_n stays high for GAP clks before the next frame may start.
- States: INIT_SCAN, INIT_SEND, IDLE, SHIFT, GAP_WAIT.
  - INIT_SCAN: the pointer walks 0..INIT_DEPTH-1 at one entry per clk. An entry with enable=0 is skipped. An entry with enable=1 sends a write to address i on ALL chip selects.
  - init_done rises the cycle after the last entry's gap completes and stays 1 until reset.
- Commands are honoured only in IDLE with init_done=1. Otherwise cmd_ack stays 0 and the request stalls; it is never dropped.
  - 0x09: tx_gain = cmd_data[31:28]. If the value is unchanged, ack only. Otherwise write addr 0x0a, data {4'b0100, tx_gain}.
  - 0x0a: rx_gain = cmd_data[6:0]. If unchanged, ack only. Otherwise write addr 0x09, data {2'b01, g}, where g = rx[6] ? rx[5:0] : (rx[5] ? ~rx[5:0] : {1'b1, rx[4:0]}).
  - 0x3b with cmd_data[31:24]==CHIP_ID: generic access. rw=cmd_data[23], cs index=cmd_data[22:21] (values >=NCS are ignored; ack only), addr=cmd_data[20:16], data=cmd_data[DATA_W-1:0].
  - Gain frames use cs 0.
  - Any other address or ID: ack only, no frame.
- cmd_ack pulses for one clk, the cycle after acceptance. The frame's sen_n falls in that same cycle. A new request is not accepted in the cycle cmd_ack is high.
- Readback: rd_data is loaded with the last DATA_W captured bits at frame end. rd_valid pulses at the clk where sen_n returns high. Writes never pulse rd_valid.
- busy = (state != IDLE) or init not done.

Test Plan:
1. Release reset with INIT_TABLE enabling entries 4 (0x36) and 7 (0x21), SCLK_HALF=1 -> exactly two 16-bit frames on all sen_n: 0x0436 then 0x0721, each 32 clks, gap >= 2; init_done rises after the second frame.
2. After init, cmd 0x0a data 0x0000_0020 -> one ack, frame 0x095F; repeat the same command -> ack with no frame.
3. cmd 0x09 data 0x5000_0000 -> frame 0x0A45; issue cmd_rqst during init -> ack withheld until init_done, then served.
4. Generic read: cmd 0x3b data 0x06A3_0000 (rw=1, cs1, addr 3), NCS=2, spi_sdo driven 0xC3 during data bits -> frame on sen_n[1] only; rd_data=0xC3 with a single rd_valid pulse.
5. Assert rst_n=0 mid-frame -> sen_n high and sclk low next edge; init restarts from entry 0; no rd_valid.
6. SCLK_HALF=3, ADDR_W=6, DATA_W=16 -> 25-bit frame, 150 clks per frame, MSB first, sen_n low for exactly 150 clks.
